arb_requester: RTL and testbench
================================

# arb_requester

Client-side agent for the two-line request/grant arbiter. It queues burst jobs from a local producer and raises `request` to the arbiter. While granted, it emits one data beat per cycle, and it drops `request` for at least one cycle between bursts so the arbiter sees a release. One instance sits in front of each arbiter request/grant pair (R0/G0, R1/G1).

## Interface
Parameters:
- DEPTH, 4: job queue entries (power of two, ≥2)
- LEN_W, 4: job length field width; a job is `job_len+1` beats
- TIMEOUT, 15: maximum cycles spent in REQ before the job is abandoned (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  producer offers a job
- job_len  in  LEN_W  beats minus one for the offered job
- job_ready  out  1  queue can accept; high when not full
- grant  in  1  grant line from the arbiter for this client
- request  out  1  request line to the arbiter
- beat  out  1  one data beat transferred this cycle
- done  out  1  one-cycle pulse when a job's final beat completes
- timeout_err  out  1  one-cycle pulse when a job is abandoned
- pending  out  $clog2(DEPTH+1)  jobs in queue, including the active one

## Operation
- Queue: FIFO of `job_len` values. Push occurs when `job_valid & job_ready`. The head is popped on completion or on timeout.
  - `job_ready = !full`, computed from the registered count only. A pop in the same cycle does not enable a push into a full queue.
  - A simultaneous push and pop leaves `pending` unchanged.
- FSM states and transitions:
  - IDLE: `request=0`. Go to REQ when the queue is not empty.
  - REQ: `request=1`. The wait counter increments each cycle.
    - When `grant` is seen, go to OWN. If `remain` is zero (fresh job), load `remain = head+1`.
    - If the wait counter reaches TIMEOUT without `grant`: pulse `timeout_err`, pop the head, clear `remain`, go to RELEASE.
    - `grant` has priority over timeout when both occur in the same cycle.
  - OWN: `request=1`. Each cycle with `grant=1`, `beat=1` and `remain` decrements.
    - When `remain` goes 1→0: pulse `done`, pop the head, go to RELEASE.
    - If `grant=0` in OWN (preemption): `beat=0`, keep `remain`, clear the wait counter, go to REQ. The burst resumes without reloading.
  - RELEASE: `request=0` for exactly one cycle, then go to IDLE.
- `job_len=0` produces a single-beat job. The maximum is 2^LEN_W beats.
- `grant` seen while in IDLE or RELEASE is ignored: no beat, no state change.
- The wait counter clears on every entry to REQ.

## Timing
- Reset values: state=IDLE, queue empty, `request=0`, `beat=0`, `done=0`, `timeout_err=0`, `pending=0`, `job_ready=1`. Reset mid-burst aborts the burst and discards all queued jobs.
- `request` is decoded from the state register (Moore). It first rises the cycle after the push that makes the queue non-empty, when starting from IDLE.
- `beat` = (state==OWN) & `grant`. This is combinational on `grant`, so the beat occurs in the same cycle as the grant.
- A job of N beats with uninterrupted grant from the first REQ cycle takes the following cycles:
  - 1 REQ cycle
  - N OWN cycles
  - 1 RELEASE cycle
  - 1 IDLE cycle, after which the next job's REQ follows
- `done` and `timeout_err` are registered pulses, asserted in the cycle after the final beat or after the timeout detection respectively. They are never high together.
- `pending` is registered and updates the cycle after a push or pop.

## Structure
- Package `arb_pkg`:
  - FSM state typedef: IDLE=2'b00, REQ=2'b01, OWN=2'b10, RELEASE=2'b11.
  - Shared request/grant width constants, also used by the arbiter.
- Sub-module `arb_len_fifo`: parameterised DEPTH×LEN_W synchronous FIFO containing:
  - push/pop
  - head data
  - full/empty
  - count
- The FSM, wait counter and beat counter live in `arb_requester`.

## Test plan
- Reset, then push len=2 with `grant` tied high → `request` rises, exactly 3 `beat` cycles, `done` pulses once, then `request` low for 1 cycle, `pending` 1→0.
- Push len=3; `grant` high 2 cycles, low 3 cycles, high again → 2 beats, return to REQ, 2 more beats after regrant, total 4 beats, single `done`.
- Push 1 job; `grant` held low with TIMEOUT=15 → `timeout_err` after the 15th REQ cycle, `beat` never asserted, `pending`=0, `request` drops.
- Push 5 jobs back-to-back with DEPTH=4 → `job_ready` low after the 4th push and the 5th is not accepted. With grant high, 4 `done` pulses occur, each followed by a RELEASE cycle with `request=0`.
- Assert `reset` mid-OWN with 2 queued jobs → `request`/`beat` are 0 immediately, `pending`=0, and no `done` pulse occurs. After release, a new len=0 job completes with 1 beat.
- `grant` pulsed while IDLE with an empty queue → no `beat`, `request` stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-client request/grant arbiter and its requesters.
package arb_pkg;

  localparam int unsigned ArbNumClients = 2;
  // One request line and one grant line per client (R0/G0, R1/G1).
  localparam int unsigned ArbReqW       = ArbNumClients;
  localparam int unsigned ArbGntW       = ArbNumClients;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StReq     = 2'b01,
    StOwn     = 2'b10,
    StRelease = 2'b11
  } req_state_e;

endpackage

// File: rtl/arb_len_fifo.sv
// Synchronous FIFO of burst lengths for the requester job queue.
module arb_len_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [LEN_W-1:0]           i_data,
  input  logic                       i_pop,
  output logic [LEN_W-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Client-side arbiter agent: queues burst jobs, requests the bus, streams beats while granted
// and releases the request for one cycle between bursts.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_job_valid,
  input  logic [LEN_W-1:0]           i_job_len,
  output logic                       o_job_ready,
  input  logic                       i_grant,
  output logic                       o_request,
  output logic                       o_beat,
  output logic                       o_done,
  output logic                       o_timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] o_pending
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned REM_W  = LEN_W + 1;

  req_state_e        r_state;
  req_state_e        w_state_d;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_d;
  logic [WAIT_W-1:0] w_wait_inc;
  logic [REM_W-1:0]  r_remain;
  logic [REM_W-1:0]  w_remain_d;
  logic              r_done;
  logic              r_tmo;
  logic              w_done_d;
  logic              w_tmo_d;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [LEN_W-1:0]  w_head;

  assign o_job_ready   = ~w_full;
  assign w_push        = i_job_valid & ~w_full;
  assign w_wait_inc    = r_wait + WAIT_W'(1);
  assign o_done        = r_done;
  assign o_timeout_err = r_tmo;

  arb_len_fifo #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (i_job_len),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_pending)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d  = r_state;
    w_wait_d   = r_wait;
    w_remain_d = r_remain;
    w_pop      = 1'b0;
    w_done_d   = 1'b0;
    w_tmo_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_wait_d = '0;
        // A push this cycle lands in the queue before the first REQ cycle reads the head.
        if (!w_empty || w_push) w_state_d = StReq;
      end
      StReq: begin
        if (i_grant) begin
          w_state_d = StOwn;
          w_wait_d  = '0;
          // Non-zero remain means a preempted burst resuming where it stopped.
          if (r_remain == '0) w_remain_d = REM_W'(w_head) + REM_W'(1);
        end else if (w_wait_inc == WAIT_W'(TIMEOUT)) begin
          w_state_d  = StRelease;
          w_pop      = 1'b1;
          w_tmo_d    = 1'b1;
          w_remain_d = '0;
          w_wait_d   = '0;
        end else begin
          w_wait_d = w_wait_inc;
        end
      end
      StOwn: begin
        if (i_grant) begin
          w_remain_d = r_remain - REM_W'(1);
          if (r_remain == REM_W'(1)) begin
            w_state_d = StRelease;
            w_pop     = 1'b1;
            w_done_d  = 1'b1;
          end
        end else begin
          w_state_d = StReq;
          w_wait_d  = '0;
        end
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_request = 1'b0;
    o_beat    = 1'b0;
    unique case (r_state)
      StReq:   o_request = 1'b1;
      StOwn: begin
        o_request = 1'b1;
        o_beat    = i_grant;
      end
      default: begin
        o_request = 1'b0;
        o_beat    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wait   <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_wait   <= w_wait_d;
      r_remain <= w_remain_d;
      r_done   <= w_done_d;
      r_tmo    <= w_tmo_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus a random job/grant stream
// scored against a job-level queue model.
module tb_arb_requester;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned TIMEOUT   = 15;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int          TRACE_MAX = 64;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             job_valid = 1'b0;
  logic [LEN_W-1:0] job_len   = '0;
  logic             grant     = 1'b0;
  logic             job_ready;
  logic             request;
  logic             beat;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  logic tr_req  [TRACE_MAX];
  logic tr_beat [TRACE_MAX];
  logic tr_done [TRACE_MAX];
  logic tr_tmo  [TRACE_MAX];
  int   tr_pend [TRACE_MAX];
  logic g_pat   [TRACE_MAX];

  // Job-level model for the random test.
  int q[$];
  int acc;
  int n_done_r;
  int n_tmo_r;

  always #5 clock = ~clock;

  arb_requester #(
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_job_valid   (job_valid),
    .i_job_len     (job_len),
    .o_job_ready   (job_ready),
    .i_grant       (grant),
    .o_request     (request),
    .o_beat        (beat),
    .o_done        (done),
    .o_timeout_err (timeout_err),
    .o_pending     (pending)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b1; job_valid = 1'b0; grant = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Cycle 0 carries the job_valid set by the caller; samples land in the tr_* arrays.
  task automatic run_trace(input int n);
    for (int k = 0; k < n; k++) begin
      grant = g_pat[k];
      @(negedge clock);
      tr_req[k] = request; tr_beat[k] = beat; tr_done[k] = done;
      tr_tmo[k] = timeout_err; tr_pend[k] = int'(pending);
      @(posedge clock);
      #1 job_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    grant = 1'b1; job_valid = 1'b1; job_len = 4'd7;
    repeat (3) @(negedge clock);
    n_checks++; if (request !== 1'b0) begin n_errors++; $display("FAIL rst_request: got %b want 0", request); end
    n_checks++; if (beat !== 1'b0) begin n_errors++; $display("FAIL rst_beat: got %b want 0", beat); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL rst_tmo: got %b want 0", timeout_err); end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL rst_pending: got %0d want 0", pending); end
    n_checks++; if (job_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", job_ready); end
    @(posedge clock);
    #1 reset = 1'b0; job_valid = 1'b0; grant = 1'b0;
    @(negedge clock);
    n_checks++; if (pending !== '0 || request !== 1'b0) begin
      n_errors++; $display("FAIL rst_no_push: pending=%0d request=%b want 0/0", pending, request);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic(input int len);
    int nb;
    logic [2:0] exp_v;
    logic [2:0] got_v;
    nb = len + 1;
    for (int k = 0; k < TRACE_MAX; k++) g_pat[k] = 1'b1;
    job_len = LEN_W'(len); job_valid = 1'b1;
    run_trace(nb + 5);
    for (int k = 0; k < nb + 5; k++) begin
      exp_v = {(k >= 1 && k <= nb + 1), (k >= 2 && k <= nb + 1), (k == nb + 2)};
      got_v = {tr_req[k], tr_beat[k], tr_done[k]};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL basic_len%0d_cyc%0d: req/beat/done=%b want %b", len, k, got_v, exp_v);
      end
    end
    n_checks++; if (tr_pend[1] != 1) begin n_errors++; $display("FAIL basic_pend_active: got %0d want 1", tr_pend[1]); end
    n_checks++; if (tr_pend[nb + 2] != 0) begin n_errors++; $display("FAIL basic_pend_after: got %0d want 0", tr_pend[nb + 2]); end
  endtask

  task automatic test_preempt();
    int b_early, b_total, n_d, n_req;
    for (int k = 0; k < TRACE_MAX; k++) g_pat[k] = 1'b1;
    g_pat[0] = 1'b0; g_pat[4] = 1'b0; g_pat[5] = 1'b0; g_pat[6] = 1'b0;
    job_len = 4'd3; job_valid = 1'b1;
    run_trace(14);
    b_early = 0; b_total = 0; n_d = 0; n_req = 0;
    for (int k = 0; k < 14; k++) begin
      if (tr_beat[k] === 1'b1) b_total++;
      if (tr_beat[k] === 1'b1 && k <= 6) b_early++;
      if (tr_done[k] === 1'b1) n_d++;
      if (tr_req[k] === 1'b1 && k >= 1 && k <= 9) n_req++;
    end
    n_checks++; if (b_early != 2) begin n_errors++; $display("FAIL pre_beats_before_regrant: got %0d want 2", b_early); end
    n_checks++; if (b_total != 4) begin n_errors++; $display("FAIL pre_beats_total: got %0d want 4", b_total); end
    n_checks++; if (n_d != 1) begin n_errors++; $display("FAIL pre_done_count: got %0d want 1", n_d); end
    n_checks++; if (tr_done[10] !== 1'b1) begin n_errors++; $display("FAIL pre_done_cycle: got %b want 1", tr_done[10]); end
    n_checks++; if (n_req != 9) begin n_errors++; $display("FAIL pre_request_held: got %0d cycles want 9", n_req); end
    n_checks++; if (tr_req[10] !== 1'b0) begin n_errors++; $display("FAIL pre_release: got %b want 0", tr_req[10]); end
    n_checks++; if (tr_pend[10] != 0) begin n_errors++; $display("FAIL pre_pending: got %0d want 0", tr_pend[10]); end
  endtask

  task automatic test_timeout();
    int n_req, n_b, n_t, n_d;
    for (int k = 0; k < TRACE_MAX; k++) g_pat[k] = 1'b0;
    job_len = LEN_W'($urandom_range(0, 15)); job_valid = 1'b1;
    run_trace(20);
    n_req = 0; n_b = 0; n_t = 0; n_d = 0;
    for (int k = 0; k < 20; k++) begin
      if (tr_req[k] === 1'b1) n_req++;
      if (tr_beat[k] === 1'b1) n_b++;
      if (tr_tmo[k] === 1'b1) n_t++;
      if (tr_done[k] === 1'b1) n_d++;
    end
    n_checks++; if (n_req != int'(TIMEOUT)) begin n_errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", n_req, TIMEOUT); end
    n_checks++; if (tr_tmo[TIMEOUT + 1] !== 1'b1) begin n_errors++; $display("FAIL tmo_pulse_cycle: got %b want 1", tr_tmo[TIMEOUT + 1]); end
    n_checks++; if (n_t != 1) begin n_errors++; $display("FAIL tmo_pulse_count: got %0d want 1", n_t); end
    n_checks++; if (n_b != 0) begin n_errors++; $display("FAIL tmo_beats: got %0d want 0", n_b); end
    n_checks++; if (n_d != 0) begin n_errors++; $display("FAIL tmo_done: got %0d want 0", n_d); end
    n_checks++; if (tr_req[TIMEOUT + 1] !== 1'b0) begin n_errors++; $display("FAIL tmo_release: got %b want 0", tr_req[TIMEOUT + 1]); end
    n_checks++; if (tr_pend[TIMEOUT] != 1 || tr_pend[TIMEOUT + 1] != 0) begin
      n_errors++; $display("FAIL tmo_pending: got %0d,%0d want 1,0", tr_pend[TIMEOUT], tr_pend[TIMEOUT + 1]);
    end
  endtask

  task automatic test_back_to_back();
    int exp_beats, n_d, n_b, n_t;
    logic exp_rdy;
    exp_beats = 0;
    grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      job_len = LEN_W'($urandom_range(0, 15)); job_valid = 1'b1;
      exp_rdy = (i < int'(DEPTH));
      @(negedge clock);
      n_checks++;
      if (job_ready !== exp_rdy) begin n_errors++; $display("FAIL b2b_ready_push%0d: got %b want %b", i, job_ready, exp_rdy); end
      if (exp_rdy) exp_beats += int'(job_len) + 1;
      if (i == 4) begin
        n_checks++; if (pending !== CNT_W'(DEPTH)) begin n_errors++; $display("FAIL b2b_pending_full: got %0d want %0d", pending, DEPTH); end
      end
      @(posedge clock);
      #1;
    end
    job_valid = 1'b0; grant = 1'b1;
    n_d = 0; n_b = 0; n_t = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clock);
      if (beat === 1'b1) n_b++;
      if (timeout_err === 1'b1) n_t++;
      if (done === 1'b1) begin
        n_d++;
        n_checks++; if (request !== 1'b0) begin n_errors++; $display("FAIL b2b_release%0d: request=%b want 0", n_d, request); end
      end
      @(posedge clock);
      #1;
    end
    n_checks++; if (n_d != 4) begin n_errors++; $display("FAIL b2b_done_count: got %0d want 4", n_d); end
    n_checks++; if (n_b != exp_beats) begin n_errors++; $display("FAIL b2b_beats: got %0d want %0d", n_b, exp_beats); end
    n_checks++; if (n_t != 0) begin n_errors++; $display("FAIL b2b_timeouts: got %0d want 0", n_t); end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL b2b_pending_end: got %0d want 0", pending); end
  endtask

  task automatic test_reset_mid();
    grant = 1'b1; job_len = 4'd5; job_valid = 1'b1;
    @(posedge clock);
    #1 job_len = 4'd3;
    @(posedge clock);
    #1 job_valid = 1'b0;
    n_checks++; if (request !== 1'b1 || beat !== 1'b1 || pending !== CNT_W'(2)) begin
      n_errors++; $display("FAIL mid_pre: req=%b beat=%b pend=%0d want 1/1/2", request, beat, pending);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (request !== 1'b0 || beat !== 1'b0) begin
      n_errors++; $display("FAIL mid_outputs: req=%b beat=%b want 0/0", request, beat);
    end
    n_checks++; if (pending !== '0) begin n_errors++; $display("FAIL mid_pending: got %0d want 0", pending); end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_checks++; if (done !== 1'b0 || request !== 1'b0) begin
        n_errors++; $display("FAIL mid_after_cyc%0d: done=%b req=%b want 0/0", c, done, request);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_idle_grant();
    for (int c = 0; c < 12; c++) begin
      grant = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      @(negedge clock);
      n_checks++; if (beat !== 1'b0 || request !== 1'b0) begin
        n_errors++; $display("FAIL idle_grant_cyc%0d: beat=%b req=%b want 0/0", c, beat, request);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rand_cycle(input bit allow_push, input bit starve);
    int sz_before;
    n_checks++;
    if ((done & timeout_err) !== 1'b0) begin n_errors++; $display("FAIL rnd_exclusive: done=%b tmo=%b want not both", done, timeout_err); end
    if (done === 1'b1 || timeout_err === 1'b1) begin
      n_checks++;
      if (request !== 1'b0) begin n_errors++; $display("FAIL rnd_release: request=%b want 0", request); end
      n_checks++;
      if (q.size() == 0) begin
        n_errors++; $display("FAIL rnd_completion: done=%b tmo=%b with no queued job", done, timeout_err);
      end else if (done === 1'b1 && acc != q[0] + 1) begin
        n_errors++; $display("FAIL rnd_done_beats: got %0d beats want %0d", acc, q[0] + 1);
      end else if (timeout_err === 1'b1 && acc > q[0]) begin
        n_errors++; $display("FAIL rnd_tmo_beats: got %0d beats want at most %0d", acc, q[0]);
      end
      if (q.size() != 0) void'(q.pop_front());
      if (done === 1'b1) n_done_r++;
      if (timeout_err === 1'b1) n_tmo_r++;
      acc = 0;
    end
    n_checks++;
    if (pending !== CNT_W'(q.size())) begin n_errors++; $display("FAIL rnd_pending: got %0d want %0d", pending, q.size()); end
    n_checks++;
    if (job_ready !== (q.size() < int'(DEPTH))) begin
      n_errors++; $display("FAIL rnd_ready: got %b want %b", job_ready, q.size() < int'(DEPTH));
    end
    sz_before = q.size();
    grant = starve ? 1'b0 : (($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    job_len = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
    job_valid = (allow_push && $urandom_range(0, 9) < 4) ? 1'b1 : 1'b0;
    if (job_valid && q.size() < int'(DEPTH)) q.push_back(int'(job_len));
    @(negedge clock);
    if (beat === 1'b1) begin
      n_checks++;
      if (request !== 1'b1 || grant !== 1'b1) begin
        n_errors++; $display("FAIL rnd_beat_cond: req=%b grant=%b want 1/1", request, grant);
      end
      n_checks++;
      if (sz_before == 0) begin
        n_errors++; $display("FAIL rnd_beat_no_job: beat=1 want 0 with empty queue");
      end else if (acc + 1 > q[0] + 1) begin
        n_errors++; $display("FAIL rnd_beat_excess: got %0d beats want at most %0d", acc + 1, q[0] + 1);
      end
      acc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    int guard;
    q.delete(); acc = 0; n_done_r = 0; n_tmo_r = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1, (c % 250) >= 220);
    guard = 0;
    while (q.size() != 0 && guard < 400) begin
      rand_cycle(1'b0, 1'b0);
      guard++;
    end
    n_checks++; if (q.size() != 0) begin n_errors++; $display("FAIL rnd_drain: %0d jobs left want 0", q.size()); end
    rand_cycle(1'b0, 1'b0);
    n_checks++; if (n_done_r == 0) begin n_errors++; $display("FAIL rnd_done_seen: got 0 done pulses want >0"); end
    n_checks++; if (n_tmo_r == 0) begin n_errors++; $display("FAIL rnd_tmo_seen: got 0 timeouts want >0"); end
  endtask

  initial begin
    test_reset();
    apply_reset(); test_basic(2);
    apply_reset(); test_basic(0);
    apply_reset(); test_basic(15);
    apply_reset(); test_basic($urandom_range(1, 14));
    apply_reset(); test_preempt();
    apply_reset(); test_timeout();
    apply_reset(); test_back_to_back();
    apply_reset(); test_reset_mid(); test_basic(0);
    apply_reset(); test_idle_grant();
    apply_reset(); test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
